dmem_access_ctrl: RTL and testbench

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

---
 rtl/dmem_access_ctrl_if.sv | 26 ++
 rtl/dmem_access_ctrl.sv | 109 ++++++++++
 tb/tb_dmem_access_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline/memory bus bundle for the data-memory access controller.
// The slave modport is the controller's view; master is the surrounding pipeline plus memory.
interface dmem_access_ctrl_if;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;

    modport slave (
        input  MemRead_i, MemWrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        output stall_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output MemRead_i, MemWrite_i, addr_i, wdata_i, mem_ack_i, mem_rdata_i,
        input  stall_o, rdata_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Stalling data-memory access controller: one outstanding load/store, IDLE -> BUSY -> DONE.
// Optional watchdog (8-bit, sticky err_o) is enabled by defining DMEM_TIMEOUT_EN.
module dmem_access_ctrl (
    input  logic              clk_i,
    input  logic              rst_i,
    dmem_access_ctrl_if.slave bus,
    output logic              err_o
);
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_BUSY = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_we;
    logic        w_access;
    logic        w_accept;
    logic        w_ack;
    logic        w_timeout;

    assign w_access = bus.MemRead_i | bus.MemWrite_i;
    assign w_accept = (r_state == S_IDLE) & w_access;
    assign w_ack    = (r_state == S_BUSY) & bus.mem_ack_i;

`ifdef DMEM_TIMEOUT_EN
    logic [7:0] r_cnt;
    logic       r_err;

    // Cleared when an access is accepted, so it reads 0 in the first BUSY cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= 8'd0;
        end else if (w_accept) begin
            r_cnt <= 8'd0;
        end else if ((r_state == S_BUSY) && !bus.mem_ack_i) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Fires in the 255th unacknowledged BUSY cycle, as the count steps to 255.
    assign w_timeout = (r_state == S_BUSY) & ~bus.mem_ack_i & (r_cnt == 8'd254);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_timeout) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    assign w_timeout = 1'b0;
    assign err_o     = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_next = w_access ? S_BUSY : S_IDLE;
            S_BUSY:  w_state_next = (bus.mem_ack_i | w_timeout) ? S_DONE : S_BUSY;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // MemWrite_i wins when both requests are raised together.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= bus.addr_i;
            r_wdata <= bus.wdata_i;
            r_we    <= bus.MemWrite_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= 32'd0;
        end else if (w_ack && !r_we) begin
            r_rdata <= bus.mem_rdata_i;
        end else if (w_timeout && !r_we) begin
            r_rdata <= 32'd0;
        end
    end

    always_comb begin
        bus.stall_o     = w_accept | (r_state == S_BUSY);
        bus.mem_req_o   = (r_state == S_BUSY);
        bus.mem_we_o    = r_we;
        bus.mem_addr_o  = r_addr & 32'hFFFF_FFFC;
        bus.mem_wdata_o = r_wdata;
        bus.rdata_o     = r_rdata;
    end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: stimulus queues expected requests/completions,
// a negedge monitor pops and compares them as the DUT issues and retires accesses.
module tb_dmem_access_ctrl;
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          cyc;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } done_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    req_t  req_q[$];
    done_t done_q[$];
    logic [31:0] exp_rdata = 32'd0;
    logic        exp_err = 1'b0;

    dmem_access_ctrl_if bus();

    dmem_access_ctrl dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus),
        .err_o (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: request starts and completions are compared against the queues.
    req_t cur_req;
    logic prev_req = 1'b0;
    logic prev_stall = 1'b0;
    always @(negedge clk) begin
        req_t  r;
        done_t d;
        if (!rst_n) begin
            prev_req   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (bus.mem_req_o && !prev_req) begin
                if (req_q.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                end else begin
                    r = req_q.pop_front();
                    cur_req = r;
                    check("req_cycle", cyc, r.cyc);
                    check("req_we", 32'(bus.mem_we_o), 32'(r.we));
                    check("req_addr", bus.mem_addr_o, r.addr);
                    if (r.we) check("req_wdata", bus.mem_wdata_o, r.wdata);
                end
            end
            if (bus.mem_req_o && prev_req) begin
                check("busy_addr_stable", bus.mem_addr_o, cur_req.addr);
                check("busy_we_stable", 32'(bus.mem_we_o), 32'(cur_req.we));
            end
            if (bus.mem_req_o) check("busy_stall", 32'(bus.stall_o), 32'd1);
            if (!bus.mem_req_o && prev_req) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_stall_low", 32'(bus.stall_o), 32'd0);
                    check("done_prev_stall", 32'(prev_stall), 32'd1);
                    check("done_rdata", bus.rdata_o, d.rdata);
                    check("done_err", 32'(err), 32'(d.err));
                    $display("txn done @cyc %0d: rdata=%h err=%0d", cyc, bus.rdata_o, err);
                end
            end
            prev_req   = bus.mem_req_o;
            prev_stall = bus.stall_o;
        end
    end

    // Presents an access at the current cycle (c0), acks it in cycle c0+n (n=0: never),
    // and returns at the start of the cycle after DONE with the inputs still held.
    task automatic do_access(input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] wd, input int n,
                             input logic [31:0] ad, input bit ack_in_done);
        int    c0;
        int    last;
        req_t  r;
        done_t d;
        c0 = cyc;
        bus.MemRead_i  = rd;
        bus.MemWrite_i = wr;
        bus.addr_i     = a;
        bus.wdata_i    = wd;
        last = (n == 0) ? 255 : n;
        r.we = wr; r.addr = a & 32'hFFFF_FFFC; r.wdata = wd; r.cyc = c0 + 1;
        req_q.push_back(r);
        if (!wr) exp_rdata = (n == 0) ? 32'd0 : ad;
        if (n == 0) exp_err = 1'b1;
        d.rdata = exp_rdata; d.err = exp_err; d.cyc = c0 + last + 1;
        done_q.push_back(d);
        @(negedge clk);
        check("stall_cycle0", 32'(bus.stall_o), 32'd1);
        for (int k = 1; k <= last; k++) begin
            @(posedge clk); #1;
            if (k == n) begin
                bus.mem_ack_i   = 1'b1;
                bus.mem_rdata_i = ad;
            end
        end
        @(posedge clk); #1;
        bus.mem_ack_i   = ack_in_done;
        bus.mem_rdata_i = 32'hBAD0_BAD0;
        @(posedge clk); #1;
        bus.mem_ack_i = 1'b0;
    endtask

    task automatic idle(input int n, input bit ack);
        bus.MemRead_i   = 1'b0;
        bus.MemWrite_i  = 1'b0;
        bus.mem_ack_i   = ack;
        bus.mem_rdata_i = 32'h5A5A_5A5A;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check("idle_stall", 32'(bus.stall_o), 32'd0);
            check("idle_req", 32'(bus.mem_req_o), 32'd0);
            check("idle_rdata", bus.rdata_o, exp_rdata);
            @(posedge clk); #1;
        end
        bus.mem_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.MemRead_i   = 1'b0;
        bus.MemWrite_i  = 1'b0;
        bus.addr_i      = 32'd0;
        bus.wdata_i     = 32'd0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", 32'(bus.stall_o), 32'd0);
        check("rst_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", bus.mem_addr_o, 32'd0);
        check("rst_we", 32'(bus.mem_we_o), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        idle(2, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_0106, 32'h0, 3, 32'hDEAD_BEEF, 1'b1);
        idle(1, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678, 1, 32'hFFFF_0000, 1'b0);
        idle(2, 1'b0);
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        do_access(1'b1, 1'b1, 32'h0000_2003, 32'hA5A5_A5A5, 4, 32'h7777_7777, 1'b0);
        idle(1, 1'b0);

`ifdef DMEM_TIMEOUT_EN
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 0, 32'h0, 1'b0);
        idle(1, 1'b0);
        do_access(1'b0, 1'b1, 32'h0000_0044, 32'h0BAD_CAFE, 2, 32'h0, 1'b0);
        idle(1, 1'b0);
        check("err_sticky", 32'(err), 32'd1);
`else
        do_access(1'b1, 1'b0, 32'h0000_0040, 32'h0, 300, 32'h0F0F_0F0F, 1'b0);
        idle(1, 1'b0);
        check("err_tied_low", 32'(err), 32'd0);
`endif

        // Reset dropped into BUSY cycle 2: the request must vanish and never come back.
        begin
            req_t r;
            r.we = 1'b0; r.addr = 32'h0000_0080; r.wdata = 32'h0; r.cyc = cyc + 1;
            req_q.push_back(r);
            bus.MemRead_i = 1'b1;
            bus.addr_i    = 32'h0000_0080;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b0;
            bus.MemRead_i = 1'b0;
            #1;
            check("rstbusy_req", 32'(bus.mem_req_o), 32'd0);
            check("rstbusy_stall", 32'(bus.stall_o), 32'd0);
            check("rstbusy_rdata", bus.rdata_o, 32'd0);
            check("rstbusy_err", 32'(err), 32'd0);
            exp_rdata = 32'd0;
            exp_err   = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            rst_n = 1'b1;
        end
        idle(3, 1'b1);
        do_access(1'b1, 1'b0, 32'h0000_0084, 32'h0, 2, 32'h1111_2222, 1'b0);
        idle(2, 1'b0);

        check("req_q_empty", req_q.size(), 32'd0);
        check("done_q_empty", done_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
